// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for a 5-stage pipeline. Drives the enable and
// clear pins of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Detects load-use hazards and taken-branch redirects, and runs a data-memory
// req/ack wait FSM with a timeout.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   id_rs1/id_rs2          ID-stage source registers, id_uses_rs1/2 qualifiers
//   ex_rd, ex_is_load      EX-stage destination register and load flag
//   ex_branch_taken        EX resolved a taken branch/jump (redirect)
//   mem_req, dmem_ack      MEM-stage access request, memory completion
//   dmem_req, dmem_err     request to data memory, one-cycle timeout pulse
//   *_en, *_clear          pipeline register enables and bubble-insert clears
//
// Optional feature (macro PIPE_PERF_EN): adds stall_cnt / flush_cnt 32-bit
// event counters. With the macro undefined these ports and registers are absent.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  dmem_ack,
  output logic                  dmem_req,
  output logic                  dmem_err,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_clear,
  output logic                  id_ex_clear,
  output logic                  ex_mem_clear,
  output logic                  mem_wb_clear
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_stall_s;
  logic timeout_s;
  logic load_use_s;
  logic branch_flush_s;
  logic lu_stall_s;

  // Load-use hazard term; x0 is never a real dependency.
  assign load_use_s = ex_is_load && (ex_rd != {REG_ADDR_W{1'b0}}) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Wait FSM next state and memory stall/timeout decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_stall_s = 1'b0;
    timeout_s   = 1'b0;
    dmem_req    = mem_req;
    case (state_q)
      S_IDLE: begin
        dmem_req = mem_req;
        if (mem_req && !dmem_ack) begin
          mem_stall_s = 1'b1;
          state_d     = S_WAIT;
          cnt_d       = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        // Ack wins over timeout when both land in the same cycle.
        if (dmem_ack) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          timeout_s = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = CNT_ZERO;
        end else begin
          mem_stall_s = 1'b1;
          cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Enable/clear decode: mem stall > branch flush > load-use. While reset is
  // held the outputs present the no-hazard values.
  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    mem_wb_en      = 1'b1;
    if_id_clear    = 1'b0;
    id_ex_clear    = 1'b0;
    ex_mem_clear   = 1'b0;
    mem_wb_clear   = 1'b0;
    dmem_err       = 1'b0;
    branch_flush_s = 1'b0;
    lu_stall_s     = 1'b0;
    if (!reset_n) begin
      pc_en = 1'b1;
    end else if (mem_stall_s) begin
      // Freeze everything upstream of MEM; bubble into WB.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_clear = 1'b1;
    end else begin
      // A timed-out access retires with its result dropped.
      mem_wb_clear = timeout_s;
      dmem_err     = timeout_s;
      if (ex_branch_taken) begin
        branch_flush_s = 1'b1;
        if_id_clear    = 1'b1;
        id_ex_clear    = 1'b1;
      end else if (load_use_s) begin
        lu_stall_s  = 1'b1;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_clear = 1'b1;
      end else begin
        lu_stall_s = 1'b0;
      end
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Performance counter next values (wrap modulo 2^32).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_stall_s || lu_stall_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (branch_flush_s || timeout_s) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed self-checking bench for pipe_hazard_ctrl with MEM_TIMEOUT=4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge. The observed vector is
// {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem,mem_wb clears,
//  dmem_req, dmem_err}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;

  // Expected output vectors.
  localparam logic [10:0] E_IDLE  = 11'b11111_0000_00; // no event, no request
  localparam logic [10:0] E_REQ   = 11'b11111_0000_10; // request, no stall
  localparam logic [10:0] E_STALL = 11'b00001_0001_10; // memory stall
  localparam logic [10:0] E_LU    = 11'b00111_0100_00; // load-use bubble
  localparam logic [10:0] E_BR    = 11'b11111_1100_00; // branch flush
  localparam logic [10:0] E_TMO   = 11'b11111_0001_11; // timeout

  logic          clk = 1'b0;
  logic          reset_n;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
  logic          mem_req, dmem_ack;
  logic          dmem_req, dmem_err;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
`ifdef PIPE_PERF_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif
  logic [10:0]   obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear,
                dmem_req, dmem_err};

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_err(dmem_err),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear),
    .ex_mem_clear(ex_mem_clear), .mem_wb_clear(mem_wb_clear)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic quiet_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    quiet_inputs();
    #2;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL reset_idle: got %b expected %b", obs, E_IDLE);
    end
    // Hazard-looking inputs must not disturb the outputs while in reset.
    mem_req = 1'b1; set_load_use(); #1;
    checks++;
    if (obs !== E_REQ) begin
      errors++; $display("FAIL reset_req: got %b expected %b", obs, E_REQ);
    end
    quiet_inputs();
    @(negedge clk); reset_n = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL post_reset: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk); quiet_inputs(); set_load_use(); #1;
    checks++;
    if (obs !== E_LU) begin
      errors++; $display("FAIL lu_rs1: got %b expected %b", obs, E_LU);
    end
    @(negedge clk); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL lu_x0: got %b expected %b", obs, E_IDLE);
    end
    @(negedge clk); quiet_inputs(); ex_is_load = 1'b1; ex_rd = 5'd7;
    id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; #1;
    checks++;
    if (obs !== E_LU) begin
      errors++; $display("FAIL lu_rs2: got %b expected %b", obs, E_LU);
    end
    @(negedge clk); id_uses_rs2 = 1'b0; #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL lu_unused: got %b expected %b", obs, E_IDLE);
    end
    @(negedge clk); quiet_inputs(); set_load_use(); ex_is_load = 1'b0; #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL lu_not_load: got %b expected %b", obs, E_IDLE);
    end
    @(negedge clk); quiet_inputs();
  endtask

  task automatic test_branch();
    @(negedge clk); quiet_inputs(); ex_branch_taken = 1'b1; #1;
    checks++;
    if (obs !== E_BR) begin
      errors++; $display("FAIL branch: got %b expected %b", obs, E_BR);
    end
    @(negedge clk); set_load_use(); #1;
    checks++;
    if (obs !== E_BR) begin
      errors++; $display("FAIL branch_over_lu: got %b expected %b", obs, E_BR);
    end
    @(negedge clk); quiet_inputs();
  endtask

  task automatic test_zero_wait();
    @(negedge clk); quiet_inputs(); mem_req = 1'b1; dmem_ack = 1'b1; #1;
    checks++;
    if (obs !== E_REQ) begin
      errors++; $display("FAIL zero_wait: got %b expected %b", obs, E_REQ);
    end
    // Still IDLE: dropping mem_req drops dmem_req.
    @(negedge clk); quiet_inputs(); #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL zero_wait_idle: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_wait3();
    logic [10:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); quiet_inputs(); mem_req = 1'b1;
      dmem_ack = (i == 3);
      // Branch and load-use held during the stall must be ignored.
      if (i < 3) begin ex_branch_taken = 1'b1; set_load_use(); end
      #1;
      exp = (i < 3) ? E_STALL : E_REQ;
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL wait3_c%0d: got %b expected %b", i, obs, exp);
      end
    end
    @(negedge clk); quiet_inputs(); #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL wait3_idle: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_timeout(input logic ack_last);
    logic [10:0] exp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); quiet_inputs(); mem_req = 1'b1;
      dmem_ack = (i == 4) && ack_last;
      #1;
      exp = (i < 4) ? E_STALL : (ack_last ? E_REQ : E_TMO);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout_ack%0d_c%0d: got %b expected %b", ack_last, i, obs, exp);
      end
    end
    @(negedge clk); quiet_inputs(); #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL timeout_idle: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); quiet_inputs(); mem_req = 1'b1; #1;
      checks++;
      if (obs !== E_STALL) begin
        errors++; $display("FAIL rmw_stall_c%0d: got %b expected %b", i, obs, E_STALL);
      end
    end
    // Counter is now 2; reset takes effect without waiting for a clock edge.
    @(negedge clk); reset_n = 1'b0; #1;
    checks++;
    if (obs !== E_REQ) begin
      errors++; $display("FAIL rmw_reset: got %b expected %b", obs, E_REQ);
    end
    mem_req = 1'b0; #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++; $display("FAIL rmw_reset_req: got %b expected %b", obs, E_IDLE);
    end
`ifdef PIPE_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL rmw_perf: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(negedge clk); reset_n = 1'b1;
    // Counter restarted: a full four-cycle stall precedes the timeout.
    test_timeout(1'b0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_zero_wait();
    test_wait3();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
